// File: rtl/ic_pkg.sv
// ic_pkg -- shared definitions for the ic_master_read Avalon read master.
// Holds the FSM state encodings, the default outstanding-read and FIFO-size
// values, and the address-step helper used by the master.
package ic_pkg;

   localparam int IC_MAX_PENDING_DEF = 4;
   localparam int IC_FIFO_DEPTH_DEF  = 64;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Next read address: byte step added modulo 2^32.
   function automatic logic [31:0] ic_next_addr(input logic [31:0] addr,
                                               input logic [2:0]  inc);
      return addr + {29'd0, inc};
   endfunction

endpackage

// File: rtl/ic_mr_pending_ctr.sv
// ic_mr_pending_ctr -- outstanding-read counter and issue permission.
// Tracks reads accepted on the bus but not yet returned, drops returns that
// arrive with nothing outstanding, and decides whether another read may be
// issued given the outstanding limit and the space left in the FIFO.
module ic_mr_pending_ctr
   import ic_pkg::*;
#(
   parameter int PEND_W     = 3,
   parameter int EFF_MAX    = 1,
   parameter int FIFO_DEPTH = IC_FIFO_DEPTH_DEF,
   parameter int FIFO_AW    = 6
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              accept_i,
   input  logic              rdv_i,
   input  logic              remain_nz_i,
   input  logic [FIFO_AW:0]  usedw_i,
   output logic [PEND_W-1:0] pending_o,
   output logic              rdv_take_o,
   output logic              can_issue_o
);

   logic [PEND_W-1:0] pend_q, pend_d;
   logic [31:0]       occupancy;

   // A return only counts while something is actually outstanding.
   assign rdv_take_o = rdv_i && (pend_q != '0);

   // Simultaneous accept and return cancel out.
   always_comb begin
      pend_d = pend_q;
      if (accept_i && !rdv_take_o) begin
         pend_d = pend_q + PEND_W'(1);
      end else if (!accept_i && rdv_take_o) begin
         pend_d = pend_q - PEND_W'(1);
      end
   end

   // Outstanding-read register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // Every outstanding read will land in the FIFO, so it counts as used space.
   assign occupancy   = 32'(usedw_i) + 32'(pend_q);
   assign can_issue_o = remain_nz_i
                        && (32'(pend_q) < 32'(EFF_MAX))
                        && (occupancy < 32'(FIFO_DEPTH));
   assign pending_o   = pend_q;

endmodule

// File: rtl/ic_master_read.sv
// ic_master_read -- Avalon-MM read master streaming words into a FIFO.
// A start pulse latches address/length/step; reads are issued while the
// outstanding limit and FIFO space allow, returned data is written to the
// FIFO one cycle after readdatavalid, and MR_done pulses at the end.
// Build option: define IC_MR_PIPELINE_EN to allow up to MAX_PENDING reads in
// flight; without it only one read is outstanding at a time.
module ic_master_read
   import ic_pkg::*;
#(
   parameter int MAX_PENDING = IC_MAX_PENDING_DEF,
   parameter int FIFO_DEPTH  = IC_FIFO_DEPTH_DEF,
   parameter int FIFO_AW     = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               MR_start,
   input  logic [31:0]        MR_address,
   input  logic [15:0]        MR_length,
   input  logic [2:0]         MR_addressinc,
   output logic               MR_read,
   output logic [31:0]        MR_readaddress,
   input  logic               MR_waitrequest,
   input  logic               MR_readdatavalid,
   input  logic [31:0]        MR_readdata,
   input  logic [FIFO_AW:0]   ff_usedw,
   output logic               ff_writerequest,
   output logic [31:0]        ff_writedata,
   output logic               MR_busy,
   output logic               MR_done
);

`ifdef IC_MR_PIPELINE_EN
   localparam int EFF_MAX = MAX_PENDING;
`else
   localparam int EFF_MAX = 1;
`endif
   localparam int PEND_W = $clog2(MAX_PENDING + 1);

   logic [1:0]        state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [2:0]        inc_q, inc_d;
   logic [15:0]       remain_q, remain_d;
   logic              hold_q;
   logic              wr_q;
   logic [31:0]       wdata_q;
   logic              done_q;
   logic              read_en;
   logic              accept;
   logic              rdv_take;
   logic              can_issue;
   logic [PEND_W-1:0] pending;

   ic_mr_pending_ctr #(
      .PEND_W     (PEND_W),
      .EFF_MAX    (EFF_MAX),
      .FIFO_DEPTH (FIFO_DEPTH),
      .FIFO_AW    (FIFO_AW)
   ) u_pending (
      .clk_i       (clk),
      .reset_i     (reset),
      .accept_i    (accept),
      .rdv_i       (MR_readdatavalid),
      .remain_nz_i (remain_q != 16'd0),
      .usedw_i     (ff_usedw),
      .pending_o   (pending),
      .rdv_take_o  (rdv_take),
      .can_issue_o (can_issue)
   );

   // A stalled read stays asserted even if permission would now be withdrawn.
   assign read_en = (state_q == ST_ISSUE) && (hold_q || can_issue);
   assign accept  = read_en && !MR_waitrequest;

   // Transfer sequencing: latch on start, step address per accepted read.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      inc_d    = inc_q;
      remain_d = remain_q;
      case (state_q)
         ST_IDLE: begin
            if (MR_start) begin
               addr_d   = MR_address;
               inc_d    = MR_addressinc;
               remain_d = MR_length;
               state_d  = (MR_length == 16'd0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (accept) begin
               addr_d   = ic_next_addr(addr_q, inc_q);
               remain_d = remain_q - 16'd1;
               if (remain_q == 16'd1) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pending == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers; reset abandons any transfer without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         inc_q    <= '0;
         remain_q <= '0;
         hold_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         inc_q    <= inc_d;
         remain_q <= remain_d;
         hold_q   <= read_en && MR_waitrequest;
         done_q   <= (state_q == ST_DONE);
      end
   end

   // FIFO write path: returned word is written one cycle after readdatavalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         wr_q <= rdv_take;
         if (rdv_take) begin
            wdata_q <= MR_readdata;
         end
      end
   end

   assign MR_read         = read_en;
   assign MR_readaddress  = addr_q;
   assign ff_writerequest = wr_q;
   assign ff_writedata    = wdata_q;
   assign MR_done         = done_q;
   assign MR_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ic_master_read.sv
// tb_ic_master_read -- self-checking bench for ic_master_read.
// Acts as an Avalon slave with a fixed memory pattern and an in-order return
// queue; a transaction-level model of the issue rules predicts every read,
// address and FIFO write. Honours IC_MR_PIPELINE_EN for the outstanding limit.
module tb_ic_master_read;

   localparam int MAXP  = 4;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
`ifdef IC_MR_PIPELINE_EN
   localparam int EFF = MAXP;
`else
   localparam int EFF = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          MR_start;
   logic [31:0]   MR_address;
   logic [15:0]   MR_length;
   logic [2:0]    MR_addressinc;
   logic          MR_read;
   logic [31:0]   MR_readaddress;
   logic          MR_waitrequest;
   logic          MR_readdatavalid;
   logic [31:0]   MR_readdata;
   logic [AW:0]   ff_usedw;
   logic          ff_writerequest;
   logic [31:0]   ff_writedata;
   logic          MR_busy;
   logic          MR_done;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   ic_master_read #(
      .MAX_PENDING (MAXP),
      .FIFO_DEPTH  (DEPTH),
      .FIFO_AW     (AW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .MR_start         (MR_start),
      .MR_address       (MR_address),
      .MR_length        (MR_length),
      .MR_addressinc    (MR_addressinc),
      .MR_read          (MR_read),
      .MR_readaddress   (MR_readaddress),
      .MR_waitrequest   (MR_waitrequest),
      .MR_readdatavalid (MR_readdatavalid),
      .MR_readdata      (MR_readdata),
      .ff_usedw         (ff_usedw),
      .ff_writerequest  (ff_writerequest),
      .ff_writedata     (ff_writedata),
      .MR_busy          (MR_busy),
      .MR_done          (MR_done)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reset in the middle of a transfer, with returns arriving during and after it.
   task automatic do_abort();
      reset            = 1'b1;
      MR_start         = 1'b0;
      MR_waitrequest   = 1'b1;
      MR_readdatavalid = 1'b1;
      MR_readdata      = $urandom;
      @(posedge clk); #1;
      reset            = 1'b0;
      MR_waitrequest   = 1'b0;
      MR_readdatavalid = 1'b1;
      MR_readdata      = $urandom;
      #1;
      chk("abort_read",  32'(MR_read), 0);
      chk("abort_addr",  MR_readaddress, 0);
      chk("abort_wreq",  32'(ff_writerequest), 0);
      chk("abort_wdata", ff_writedata, 0);
      chk("abort_busy",  32'(MR_busy), 0);
      @(posedge clk); #1;
      MR_readdatavalid = 1'b0;
      #1;
      chk("stray_wreq", 32'(ff_writerequest), 0);
      for (int i = 0; i < 4; i++) begin
         chk("abort_done", 32'(MR_done), 0);
         chk("abort_idle_read", 32'(MR_read), 0);
         @(posedge clk); #2;
      end
   endtask

   // One transfer against the slave model; checks every cycle and the totals.
   task automatic run_xfer(input logic [31:0] addr, input int len, input int inc,
                           input int lat_min, input int lat_max, input int wait_pct,
                           input int stall_idx, input int stall_len,
                           input int usedw_val, input int usedw_until,
                           input int abort_after);
      int          ret_cyc[$];
      logic [31:0] ret_addr[$];
      logic [31:0] exp_addr, prev_data;
      int          accepted, returned, dut_acc, wr_cnt, done_cnt, done_cyc;
      int          stall_cnt, last_ret, out, r, uw;
      logic        rdv_now, prev_rdv, prev_hold, exp_read;
      exp_addr = addr;  prev_data = '0;  prev_rdv = 1'b0;  prev_hold = 1'b0;
      accepted = 0; returned = 0; dut_acc = 0; wr_cnt = 0; done_cnt = 0;
      done_cyc = -1; stall_cnt = 0; last_ret = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(posedge clk); #1;
         if (abort_after > 0 && accepted == abort_after) begin
            do_abort();
            return;
         end
         MR_start      = (cyc == 0) || (cyc == 3 && accepted < len);
         MR_address    = (cyc == 0) ? addr : $urandom;
         MR_length     = (cyc == 0) ? 16'(len) : 16'($urandom);
         MR_addressinc = (cyc == 0) ? 3'(inc) : 3'($urandom);
         rdv_now = (ret_cyc.size() > 0) && (ret_cyc[0] <= cyc);
         if (rdv_now) begin
            MR_readdata = mem_word(ret_addr[0]);
            void'(ret_cyc.pop_front());
            void'(ret_addr.pop_front());
         end else begin
            MR_readdata = $urandom;
         end
         MR_readdatavalid = rdv_now;
         uw = (cyc < usedw_until) ? usedw_val : 0;
         ff_usedw = 7'(uw);
         if (accepted == stall_idx && stall_cnt < stall_len) MR_waitrequest = 1'b1;
         else MR_waitrequest = (int'($urandom_range(0, 99)) < wait_pct);
         out = accepted - returned;
         exp_read = prev_hold || (cyc >= 1 && accepted < len && out < EFF && out + uw < DEPTH);
         #1;
         chk("read", 32'(MR_read), 32'(exp_read));
         if (exp_read) chk("raddr", MR_readaddress, exp_addr);
         chk("wreq", 32'(ff_writerequest), 32'(prev_rdv));
         if (prev_rdv) chk("wdata", ff_writedata, prev_data);
         if (cyc == 1 || (cyc >= 1 && (accepted < len || returned < len)))
            chk("busy", 32'(MR_busy), 1);
         if (done_cnt > 0) chk("idle_after_done", 32'(MR_busy), 0);
         if (MR_read && !MR_waitrequest) dut_acc++;
         if (ff_writerequest) wr_cnt++;
         if (MR_done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_after_data", returned, len);
         end
         if (exp_read && MR_waitrequest && accepted == stall_idx) stall_cnt++;
         if (exp_read && !MR_waitrequest) begin
            r = cyc + int'($urandom_range(lat_min, lat_max));
            if (r <= last_ret) r = last_ret + 1;
            last_ret = r;
            ret_cyc.push_back(r);
            ret_addr.push_back(exp_addr);
            accepted++;
            exp_addr = exp_addr + 32'(inc);
         end
         if (rdv_now) returned++;
         prev_rdv  = rdv_now;
         prev_data = MR_readdata;
         prev_hold = exp_read && MR_waitrequest;
         if (done_cnt > 0 && cyc >= done_cyc + 2) break;
      end
      MR_start = 1'b0;  MR_readdatavalid = 1'b0;  MR_waitrequest = 1'b0;  ff_usedw = '0;
      chk("n_reads",  dut_acc, len);
      chk("n_writes", wr_cnt, len);
      chk("n_done",   done_cnt, 1);
      if (len == 0) chk("done_latency", done_cyc, 2);
   endtask

   initial begin
      reset = 1'b1;  MR_start = 1'b0;  MR_address = '0;  MR_length = '0;
      MR_addressinc = '0;  MR_waitrequest = 1'b0;  MR_readdatavalid = 1'b0;
      MR_readdata = '0;  ff_usedw = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_read",  32'(MR_read), 0);
      chk("rst_addr",  MR_readaddress, 0);
      chk("rst_wreq",  32'(ff_writerequest), 0);
      chk("rst_wdata", ff_writedata, 0);
      chk("rst_done",  32'(MR_done), 0);
      chk("rst_busy",  32'(MR_busy), 0);
      reset = 1'b0;

      // Basic 4-word burst, zero wait, return 2 cycles after each read.
      run_xfer(32'h0000_1000, 4, 4, 2, 2, 0, -1, 0, 0, 0, 0);
      // Second read stalled by waitrequest for 3 cycles.
      run_xfer(32'h0000_1000, 4, 4, 2, 2, 0, 1, 3, 0, 0, 0);
      // FIFO nearly full: usedw 62 throttles outstanding reads until released.
      run_xfer(32'h0000_2000, 8, 4, 3, 5, 0, -1, 0, 62, 30, 0);
      // Zero-length transfer.
      run_xfer(32'h0000_3000, 0, 4, 2, 2, 0, -1, 0, 0, 0, 0);
      // Address wrap past 0xFFFFFFFC.
      run_xfer(32'hFFFF_FFFC, 2, 4, 2, 2, 0, -1, 0, 0, 0, 0);
      // Reset after 2 of 8 reads, then a stray return.
      run_xfer(32'h0000_4000, 8, 4, 2, 2, 0, -1, 0, 0, 0, 2);
      // Recovery after the abort, with some random waits.
      run_xfer(32'h0000_5000, 3, 4, 1, 3, 20, -1, 0, 0, 0, 0);
      // Randomized transfers.
      for (int k = 0; k < 6; k++) begin
         run_xfer($urandom, int'($urandom_range(1, 10)), int'($urandom_range(0, 7)),
                  1, 4, 30, -1, 0, int'($urandom_range(56, 63)),
                  int'($urandom_range(0, 40)), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ic_master_read.md
IC_MASTER_READ -- requirements
Module: ic_master_read

Interface
REQ-001 The block SHALL have parameter MAX_PENDING, default 4, giving the maximum outstanding Avalon reads (1..15).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 64, giving the words of the downstream FIFO.
REQ-003 The block SHALL have parameter FIFO_AW, default 6, giving the ff_usedw width minus 1.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port MR_start, input, 1 bit: one-cycle pulse that starts a transfer.
REQ-007 The block SHALL have ports MR_address (input, 32 bits, start byte address), MR_length (input, 16 bits, word count) and MR_addressinc (input, 3 bits, byte step per word).
REQ-008 The block SHALL have ports MR_read (output, 1 bit, Avalon read strobe) and MR_readaddress (output, 32 bits).
REQ-009 The block SHALL have ports MR_waitrequest (input, 1 bit), MR_readdatavalid (input, 1 bit) and MR_readdata (input, 32 bits).
REQ-010 The block SHALL have ports ff_usedw (input, FIFO_AW+1 bits, FIFO fill level), ff_writerequest (output, 1 bit) and ff_writedata (output, 32 bits).
REQ-011 The block SHALL have ports MR_busy (output, 1 bit) and MR_done (output, 1 bit, one-cycle completion pulse).

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-013 In IDLE, MR_start SHALL latch the address and length; with length 0 the FSM SHALL go to DONE, otherwise to ISSUE.
REQ-014 In ISSUE, MR_read SHALL assert only when remaining-to-issue > 0, pending < MAX_PENDING and ff_usedw + pending < FIFO_DEPTH.
REQ-015 While MR_read=1 and MR_waitrequest=1, MR_read and MR_readaddress SHALL hold stable.
REQ-016 A read SHALL be accepted in a cycle with MR_read=1 and MR_waitrequest=0; on acceptance the address SHALL advance by MR_addressinc (mod 2^32), the issue count SHALL decrement and pending SHALL increment.
REQ-017 On MR_readdatavalid with pending > 0, the block SHALL register ff_writedata <= MR_readdata and pulse ff_writerequest in the next cycle (latency 1), and pending SHALL decrement.
REQ-018 When an acceptance and a readdatavalid occur in the same cycle, pending SHALL remain unchanged.
REQ-019 MR_readdatavalid while pending == 0 SHALL be ignored, including stale returns after a reset.
REQ-020 When the last read is accepted the FSM SHALL go to DRAIN; when pending reaches 0 in DRAIN it SHALL go to DONE.
REQ-021 DONE SHALL pulse MR_done for one cycle and then return to IDLE.
REQ-022 MR_busy SHALL be 1 in every state except IDLE.
REQ-023 MR_start SHALL be ignored outside IDLE.

Reset
REQ-024 On reset the FSM SHALL go to IDLE, with MR_read=0, ff_writerequest=0, MR_done=0, MR_busy=0, MR_readaddress=0, ff_writedata=0, and pending and issue counters at 0.
REQ-025 Reset mid-transfer SHALL abort the transfer without raising MR_done.

Configuration
REQ-026 When IC_MR_PIPELINE_EN is defined, up to MAX_PENDING reads SHALL be outstanding.
REQ-027 When IC_MR_PIPELINE_EN is undefined, the effective MAX_PENDING SHALL be 1, so the next read waits for the previous readdatavalid; all other behaviour is identical.

Structure
REQ-028 FSM state encodings and the MAX_PENDING and FIFO_DEPTH defaults SHALL be defined in shared package ic_pkg.
REQ-029 The pending counter and the issue-permission logic SHALL be implemented in sub-module ic_mr_pending_ctr.

Verification
REQ-030 The bench SHALL cover: address 0x1000, length 4, addressinc 4, zero wait, readdatavalid 2 cycles after each read -> reads at 0x1000/0x1004/0x1008/0x100C, 4 FIFO writes in order, MR_done pulse once.
REQ-031 The bench SHALL cover: MR_waitrequest held for 3 cycles on the 2nd read -> MR_readaddress stable at 0x1004 for those cycles, with no lost or duplicated word.
REQ-032 The bench SHALL cover: ff_usedw = 62 with FIFO_DEPTH 64 -> at most 2 reads outstanding until usedw drops.
REQ-033 The bench SHALL cover: MR_length = 0 -> MR_done exactly 2 cycles after MR_start, with no MR_read.
REQ-034 The bench SHALL cover: address 0xFFFFFFFC, addressinc 4, length 2 -> second read at 0x00000000.
REQ-035 The bench SHALL cover: reset after 2 of 8 reads, then a stray readdatavalid -> no ff_writerequest and no MR_done; both macro settings pass all other scenarios.
